// File: rtl/bpsk_frame_tx.sv
// Purpose : frames one AXI-stream message as preamble, start code, length, body,
//           CRC-8 and postamble, optionally differentially encodes it, and emits
//           upsampled +/-1 fixed-point symbols on the DAC sample strobe.
// Latency : 1 clock from the tlast beat to the transmit states; the first symbol
//           then waits for the next new_sample strobe.
// Backpr. : s_axis_tready is high only in LOAD/DRAIN with en high. A beat is
//           taken when tvalid && tready. en low freezes all state.
// Ports   : clk, rst (async, active-high), en, new_sample,
//           s_axis_tdata/tvalid/tlast/tready, sample, busy, frame_done, overflow.
module bpsk_frame_tx #(
  parameter int SYMBOL_WIDTH = 16,
  parameter int SYMBOL_FRAC = 14,
  parameter int SPS = 120,
  parameter int SYNC_LEN = 32,
  parameter int START_CODE_LEN = 11,
  parameter logic [START_CODE_LEN-1:0] START_CODE = 11'b11100010010,
  parameter int MAX_LEN = 256,
  parameter int LEN_WIDTH = 8,
  parameter bit CRC_EN = 1'b1,
  parameter bit DIFF_ENC = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    new_sample,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [SYMBOL_WIDTH-1:0] sample,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int SPS_W = $clog2(SPS);
  localparam int NW    = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // Bit counter must hold the longest field: body, sync, start code or length.
  localparam int F1 = (8 * MAX_LEN > SYNC_LEN) ? 8 * MAX_LEN : SYNC_LEN;
  localparam int F2 = (F1 > START_CODE_LEN) ? F1 : START_CODE_LEN;
  localparam int F3 = (F2 > LEN_WIDTH) ? F2 : LEN_WIDTH;
  localparam int BW = $clog2(F3 + 1);

  localparam logic [SYMBOL_WIDTH-1:0]   SYM_POS = SYMBOL_WIDTH'(1) << SYMBOL_FRAC;
  localparam logic [SYMBOL_WIDTH-1:0]   SYM_NEG = SYMBOL_WIDTH'(0) - SYM_POS;
  localparam logic [START_CODE_LEN-1:0] SC_TOP  = {1'b1, {(START_CODE_LEN-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0]      LEN_TOP = {1'b1, {(LEN_WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, LOAD, DRAIN, PRESYNC, STARTCODE, LEN, BODY, CRC, POSTSYNC
  } state_t;

  state_t               state;
  logic [7:0]           body_mem [MAX_LEN];
  logic [NW-1:0]        n;
  logic [7:0]           crc;
  logic                 d_prev;
  logic                 b2b;       // message arrived straight after POSTSYNC: skip preamble
  logic [BW-1:0]        bit_cnt;
  logic [SPS_W-1:0]     sps_cnt;

  logic                 tx_state;
  logic                 enc_state;
  logic                 tx_bit;
  logic                 sym_bit;
  logic [BW-1:0]        field_len;
  logic [7:0]           body_byte;
  logic [LEN_WIDTH-1:0] len_field;
  logic                 wr_en;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign s_axis_tready = en && (state == LOAD || state == DRAIN);
  assign busy          = (state != IDLE);
  assign tx_state      = (state != IDLE) && (state != LOAD) && (state != DRAIN);
  assign enc_state     = DIFF_ENC && (state == STARTCODE || state == LEN ||
                                      state == BODY || state == CRC);
  assign len_field     = LEN_WIDTH'(n - NW'(1));
  assign body_byte     = body_mem[bit_cnt[AW+2:3]];
  assign sym_bit       = enc_state ? (tx_bit ^ d_prev) : tx_bit;
  assign wr_en         = en && (state == LOAD) && s_axis_tvalid;

  // Current field length and the raw bit at bit_cnt, MSB first. Masks shifted by
  // bit_cnt keep the indexing width-clean for any parameter set.
  always_comb begin
    field_len = BW'(SYNC_LEN);
    tx_bit    = 1'b0;
    case (state)
      PRESYNC, POSTSYNC: begin
        field_len = BW'(SYNC_LEN);
        tx_bit    = bit_cnt[0];
      end
      STARTCODE: begin
        field_len = BW'(START_CODE_LEN);
        tx_bit    = |(START_CODE & (SC_TOP >> bit_cnt));
      end
      LEN: begin
        field_len = BW'(LEN_WIDTH);
        tx_bit    = |(len_field & (LEN_TOP >> bit_cnt));
      end
      BODY: begin
        field_len = BW'({n, 3'b000});
        tx_bit    = |(body_byte & (8'h80 >> bit_cnt[2:0]));
      end
      CRC: begin
        field_len = BW'(8);
        tx_bit    = |(crc & (8'h80 >> bit_cnt[2:0]));
      end
      default: ;
    endcase
  end

  // Body buffer has no reset; its contents only matter below N.
  always_ff @(posedge clk) begin
    if (wr_en) body_mem[n[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n          <= '0;
      crc        <= '0;
      d_prev     <= 1'b0;
      b2b        <= 1'b0;
      bit_cnt    <= '0;
      sps_cnt    <= '0;
      sample     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (s_axis_tvalid) begin
              state <= LOAD;
              n     <= '0;
              crc   <= '0;
              b2b   <= 1'b0;
            end
          end
          LOAD: begin
            if (s_axis_tvalid) begin
              n   <= n + NW'(1);
              crc <= crc8_byte(crc, s_axis_tdata);
              if (s_axis_tlast) begin
                state  <= b2b ? STARTCODE : PRESYNC;
                d_prev <= 1'b0;
              end else if (n == NW'(MAX_LEN - 1)) begin
                overflow <= 1'b1;
                state    <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (s_axis_tvalid && s_axis_tlast) begin
              state  <= b2b ? STARTCODE : PRESYNC;
              d_prev <= 1'b0;
            end
          end
          default: ;
        endcase

        if (new_sample) begin
          if (!tx_state) begin
            sample <= '0;
          end else begin
            // First strobe of a bit carries the symbol, the rest are zero-stuffed.
            if (sps_cnt == '0) begin
              sample <= sym_bit ? SYM_POS : SYM_NEG;
              if (enc_state) d_prev <= sym_bit;
            end else begin
              sample <= '0;
            end
            if (sps_cnt == SPS_W'(SPS - 1)) begin
              sps_cnt <= '0;
              if (bit_cnt == field_len - BW'(1)) begin
                bit_cnt <= '0;
                case (state)
                  PRESYNC: begin
                    state  <= STARTCODE;
                    d_prev <= 1'b0;
                  end
                  STARTCODE: state <= LEN;
                  LEN:       state <= BODY;
                  BODY:      state <= CRC_EN ? CRC : POSTSYNC;
                  CRC:       state <= POSTSYNC;
                  POSTSYNC: begin
                    frame_done <= 1'b1;
                    if (s_axis_tvalid) begin
                      state <= LOAD;
                      n     <= '0;
                      crc   <= '0;
                      b2b   <= 1'b1;
                    end else begin
                      state <= IDLE;
                    end
                  end
                  default: state <= IDLE;
                endcase
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              sps_cnt <= sps_cnt + SPS_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_frame_tx.sv
// Purpose : directed bench for bpsk_frame_tx; two instances (plain and
//           differential) share stimulus, the captured strobe stream is decoded
//           back to bits and compared with hand-built frames.
module tb_bpsk_frame_tx;

  localparam int SPS = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        new_sample;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        rdy_a, rdy_b;
  logic [15:0] sample_a, sample_b;
  logic        busy_a, busy_b;
  logic        fd_a, fd_b;
  logic        ov_a, ov_b;

  bpsk_frame_tx #(
    .SPS(SPS), .SYNC_LEN(4), .MAX_LEN(4), .CRC_EN(1'b1), .DIFF_ENC(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .new_sample(new_sample),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(rdy_a), .sample(sample_a), .busy(busy_a),
    .frame_done(fd_a), .overflow(ov_a)
  );

  bpsk_frame_tx #(
    .SPS(SPS), .SYNC_LEN(4), .MAX_LEN(4), .CRC_EN(1'b1), .DIFF_ENC(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .new_sample(new_sample),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(rdy_b), .sample(sample_b), .busy(busy_b),
    .frame_done(fd_b), .overflow(ov_b)
  );

  // Hand-built frames, first transmitted bit in the MSB.
  localparam logic [42:0] F_A5   = {4'b0101, 11'b11100010010, 8'h00, 8'hA5, 8'h72, 4'b0101};
  localparam logic [42:0] F_00   = {4'b0101, 11'b11100010010, 8'h00, 8'h00, 8'h00, 4'b0101};
  localparam logic [42:0] F_DIFF = {4'b0101, 11'b10111100011, 8'hFF, 8'hFF, 8'hFF, 4'b0101};
  localparam logic [66:0] F_OVF  = {4'b0101, 11'b11100010010, 8'h03,
                                    8'h01, 8'h02, 8'h03, 8'h04, 8'hE3, 4'b0101};
  localparam logic [81:0] F_B2B  = {F_A5, 11'b11100010010, 8'h00, 8'h00, 8'h00, 4'b0101};

  int total = 0;
  int bad = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] prev_a;
  bit   capture = 1'b0;
  int   fd_cnt_a = 0;
  int   ov_cnt_a = 0;
  int   ov_beat_a = 0;
  int   beats = 0;
  int   frz_chg = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobe every third clock, changed on the falling edge.
  initial begin
    new_sample = 1'b0;
    forever begin
      repeat (2) @(negedge clk);
      new_sample = 1'b1;
      @(negedge clk);
      new_sample = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (capture && new_sample && en) begin
      qa.push_back(sample_a);
      qb.push_back(sample_b);
    end
    if (!en && sample_a != prev_a) frz_chg++;
    prev_a = sample_a;
    if (fd_a) fd_cnt_a++;
    if (ov_a) begin
      ov_cnt_a++;
      ov_beat_a = beats;
    end
  end

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "bench timed out");
  end

  task automatic start_test();
    qa.delete();
    qb.delete();
    fd_cnt_a = 0;
    ov_cnt_a = 0;
    ov_beat_a = 0;
    beats = 0;
    frz_chg = 0;
    capture = 1'b1;
  endtask

  task automatic send(input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++) begin
      int budget;
      budget = 0;
      @(negedge clk);
      tdata  = d[i];
      tvalid = 1'b1;
      tlast  = (i == d.size() - 1);
      while (!rdy_a) begin
        @(negedge clk);
        budget++;
        if (budget > 2000) begin
          check("send tready", rdy_a, 1);
          tvalid = 1'b0;
          tlast  = 1'b0;
          return;
        end
      end
      @(posedge clk);
      beats++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 0;
    while (fd_cnt_a < target && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    repeat (30) @(negedge clk);
  endtask

  // Decode a strobe stream: symbol on every SPS-th strobe from the first
  // non-zero one, zeros elsewhere and after the frame.
  task automatic check_frame(input string tag, input logic [15:0] q[$],
                             input logic [127:0] exp_v, input int exp_n);
    logic [127:0] got_v;
    int s, nb, stray, trail;
    got_v = '0;
    s = -1;
    nb = 0;
    stray = 0;
    trail = 0;
    for (int i = 0; i < q.size(); i++) if (s < 0 && q[i] != 16'h0) s = i;
    if (s < 0) s = q.size();
    for (int i = s; i < q.size(); i++) begin
      int rel;
      rel = i - s;
      if (rel < exp_n * SPS) begin
        if (rel % SPS == 0) begin
          if (q[i] == 16'h4000) begin
            got_v = {got_v[126:0], 1'b1};
            nb++;
          end else if (q[i] == 16'hC000) begin
            got_v = {got_v[126:0], 1'b0};
            nb++;
          end else begin
            stray++;
          end
        end else if (q[i] != 16'h0) begin
          stray++;
        end
      end else if (q[i] != 16'h0) begin
        trail++;
      end
    end
    check({tag, " bits"}, got_v, exp_v);
    check({tag, " nbits"}, nb, exp_n);
    check({tag, " stray"}, stray, 0);
    check({tag, " trail"}, trail, 0);
  endtask

  initial begin
    logic [7:0] pkt[$];
    int budget;
    rst = 1'b1;
    en = 1'b1;
    tdata = 8'h00;
    tvalid = 1'b0;
    tlast = 1'b0;
    prev_a = 16'h0;

    repeat (2) @(negedge clk);
    check("rst sample", sample_a, 0);
    check("rst sample_b", sample_b, 0);
    check("rst busy", busy_a, 0);
    check("rst frame_done", fd_a, 0);
    check("rst overflow", ov_a, 0);
    check("rst tready", rdy_a, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single 0xA5 frame
    start_test();
    pkt = '{8'hA5};
    send(pkt);
    wait_done(1);
    check_frame("a5", qa, F_A5, 43);
    check("a5 frame_done", fd_cnt_a, 1);
    check("a5 busy", busy_a, 0);
    check("a5 overflow", ov_cnt_a, 0);

    // Overflow: 6 bytes into a 4-byte buffer
    start_test();
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(pkt);
    wait_done(1);
    check_frame("ovf", qa, F_OVF, 67);
    check("ovf count", ov_cnt_a, 1);
    check("ovf beat", ov_beat_a, 4);
    check("ovf beats", beats, 6);

    // Zero body: plain and differential instances
    start_test();
    pkt = '{8'h00};
    send(pkt);
    wait_done(1);
    check_frame("plain00", qa, F_00, 43);
    check_frame("diff", qb, F_DIFF, 43);

    // Back-to-back: second message waiting at the end of POSTSYNC
    start_test();
    pkt = '{8'hA5};
    send(pkt);
    pkt = '{8'h00};
    send(pkt);
    wait_done(2);
    check_frame("b2b", qa, F_B2B, 82);
    check("b2b frame_done", fd_cnt_a, 2);

    // en low for 10 cycles mid-BODY
    start_test();
    pkt = '{8'hA5};
    send(pkt);
    repeat (300) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    check("en busy", busy_a, 1);
    en = 1'b1;
    wait_done(1);
    check("en frozen", frz_chg, 0);
    check_frame("en", qa, F_A5, 43);

    // Async reset mid-BODY, then a clean frame
    start_test();
    pkt = '{8'hA5};
    send(pkt);
    repeat (300) @(negedge clk);
    budget = 0;
    while (sample_a == 16'h0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("pre-rst symbol", (sample_a != 16'h0), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst sample", sample_a, 0);
    check("mid rst busy", busy_a, 0);
    check("mid rst sample_b", sample_b, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_test();
    pkt = '{8'hA5};
    send(pkt);
    wait_done(1);
    check_frame("post rst", qa, F_A5, 43);
    check("post rst frame_done", fd_cnt_a, 1);

    capture = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
